// File: rtl/sifh_peak_scan_pkg.sv
// Shared defaults and FSM state encoding for the SiFH peak-scan stage.
package sifh_peak_scan_pkg;

  localparam int unsigned BIN_BITS_DEF = 6;
  localparam int unsigned PIX_BITS_DEF = 2;
  localparam int unsigned PEAK_MAX_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_EMIT  = 3'd3,
    S_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/sifh_peak_scan_if.sv
// Histogram RAM ports (read B / clear A) and peak-result handshake of the peak-scan stage.
interface sifh_peak_scan_if
  import sifh_peak_scan_pkg::*;
#(
  parameter int unsigned BIN_BITS = BIN_BITS_DEF,
  parameter int unsigned PIX_BITS = PIX_BITS_DEF,
  parameter int unsigned PEAK_MAX = PEAK_MAX_DEF
);
  localparam int unsigned ADDR_BITS = PIX_BITS + BIN_BITS;

  logic                 rd_en;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [PEAK_MAX-1:0]  rd_data;
  logic                 clr_en;
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 pk_valid;
  logic                 pk_ready;
  logic [PIX_BITS-1:0]  pk_pixel;
  logic [BIN_BITS-1:0]  pk_bin;
  logic [PEAK_MAX-1:0]  pk_count;

  modport master (
    output rd_en, rd_addr, clr_en, clr_addr,
    output pk_valid, pk_pixel, pk_bin, pk_count,
    input  rd_data, pk_ready
  );

  modport slave (
    input  rd_en, rd_addr, clr_en, clr_addr,
    input  pk_valid, pk_pixel, pk_bin, pk_count,
    output rd_data, pk_ready
  );

endinterface

// File: rtl/sifh_max_track.sv
// Running maximum of one pixel's bin counts: first sample loads, later samples win only if strictly greater.
module sifh_max_track
  import sifh_peak_scan_pkg::*;
#(
  parameter int unsigned BIN_BITS = BIN_BITS_DEF,
  parameter int unsigned PEAK_MAX = PEAK_MAX_DEF
) (
  input  logic                clk,
  input  logic                res,
  input  logic                smp_vld_i,
  input  logic                first_i,
  input  logic [PEAK_MAX-1:0] data_i,
  input  logic [BIN_BITS-1:0] bin_i,
  output logic [PEAK_MAX-1:0] max_cnt_o,
  output logic [BIN_BITS-1:0] max_bin_o
);

  logic [PEAK_MAX-1:0] max_cnt_q, max_cnt_d;
  logic [BIN_BITS-1:0] max_bin_q, max_bin_d;

  // Strict compare keeps the lowest bin on ties.
  always_comb begin
    max_cnt_d = max_cnt_q;
    max_bin_d = max_bin_q;
    if (smp_vld_i && (first_i || (data_i > max_cnt_q))) begin
      max_cnt_d = data_i;
      max_bin_d = bin_i;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      max_cnt_q <= '0;
      max_bin_q <= '0;
    end else begin
      max_cnt_q <= max_cnt_d;
      max_bin_q <= max_bin_d;
    end
  end

  assign max_cnt_o = max_cnt_q;
  assign max_bin_o = max_bin_q;

endmodule

// File: rtl/sifh_peak_scan.sv
// Post-frame scan of the per-pixel histogram RAM: emits each pixel's peak bin and optionally
// clears every bin behind the read pointer so the RAM is clean for the next frame.
module sifh_peak_scan
  import sifh_peak_scan_pkg::*;
#(
  parameter int unsigned BIN_BITS      = BIN_BITS_DEF,
  parameter int unsigned PIX_BITS      = PIX_BITS_DEF,
  parameter int unsigned PEAK_MAX      = PEAK_MAX_DEF,
  parameter int unsigned CLEAR_ON_READ = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  output logic             busy,
  output logic             done,
  sifh_peak_scan_if.master bus
);

  localparam int unsigned ADDR_BITS = PIX_BITS + BIN_BITS;
  localparam bit          CLEAR_EN  = (CLEAR_ON_READ != 0);

  state_e               state_q, state_d;
  logic [PIX_BITS-1:0]  pix_q, pix_d;
  logic [BIN_BITS-1:0]  bin_q, bin_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 pk_valid_q, pk_valid_d;

  // Read-address delay line: tags rd_data with its bin and addresses the clear write.
  logic                 smp_vld_q;
  logic [ADDR_BITS-1:0] smp_addr_q;
  logic                 clr_en_q;
  logic                 first_c;
  logic [PEAK_MAX-1:0]  max_cnt;
  logic [BIN_BITS-1:0]  max_bin;

  assign first_c = (smp_addr_q[BIN_BITS-1:0] == '0);

  sifh_max_track #(
    .BIN_BITS (BIN_BITS),
    .PEAK_MAX (PEAK_MAX)
  ) u_max_track (
    .clk       (clk),
    .res       (res),
    .smp_vld_i (smp_vld_q),
    .first_i   (first_c),
    .data_i    (bus.rd_data),
    .bin_i     (smp_addr_q[BIN_BITS-1:0]),
    .max_cnt_o (max_cnt),
    .max_bin_o (max_bin)
  );

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    bin_d      = bin_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    pk_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          pix_d   = '0;
          bin_d   = '0;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      S_READ: begin
        if (&bin_q) begin
          state_d = S_DRAIN;
        end else begin
          bin_d   = bin_q + BIN_BITS'(1);
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        state_d    = S_EMIT;
        pk_valid_d = 1'b1;
      end
      S_EMIT: begin
        if (bus.pk_ready) begin
          if (&pix_q) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            pix_d   = pix_q + PIX_BITS'(1);
            bin_d   = '0;
            rd_en_d = 1'b1;
          end
        end else begin
          pk_valid_d = 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
    rd_addr_d = rd_en_d ? {pix_d, bin_d} : rd_addr_q;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      bin_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      pk_valid_q <= 1'b0;
      smp_vld_q  <= 1'b0;
      smp_addr_q <= '0;
      clr_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      bin_q      <= bin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      pk_valid_q <= pk_valid_d;
      smp_vld_q  <= rd_en_q;
      smp_addr_q <= rd_addr_q;
      clr_en_q   <= rd_en_q & CLEAR_EN;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.clr_en   = clr_en_q;
  assign bus.clr_addr = smp_addr_q;
  assign bus.pk_valid = pk_valid_q;
  assign bus.pk_pixel = pix_q;
  assign bus.pk_bin   = max_bin;
  assign bus.pk_count = max_cnt;

endmodule
